// File: rtl/data_memory_ws.sv
// MEM-stage data memory with byte-lane writes, programmable wait states and a
// ready handshake that freezes the pipeline while an access is in flight.
module data_memory_ws #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 64,
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int          WAIT_CYCLES  = 3,
  parameter int          INIT_PATTERN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   mem_result,
  output logic                    addr_err
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef word_t mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = (INIT_PATTERN == 1) ? word_t'(i) : '0;
    return m;
  endfunction

  mem_t mem = init_mem();

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  word_t           wdata_q, wdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic            wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  word_t           result_q, result_d;
  logic            err_q, err_d;

  logic            req, capture, enter_done, in_range;
  logic [31:0]     acc_addr, offs, idx_full;
  word_t           acc_wdata, wr_word;
  logic [NB-1:0]   acc_be;
  logic            acc_wr;
  logic [AW-1:0]   idx;

  assign req     = mem_read | mem_write;
  assign capture = (state_q == IDLE) && req;

  // With zero wait states the access completes on the capture edge, so the
  // port values have to be used directly instead of the captured copies.
  assign acc_addr  = capture ? address   : addr_q;
  assign acc_wdata = capture ? wdata     : wdata_q;
  assign acc_be    = capture ? byte_en   : be_q;
  assign acc_wr    = capture ? mem_write : wr_q;

  assign offs     = acc_addr - BASE_ADDR;
  assign idx_full = offs >> OFS;
  assign in_range = (acc_addr >= BASE_ADDR) && (idx_full < 32'(DEPTH));
  assign idx      = idx_full[AW-1:0];

  assign enter_done = ((state_q == BUSY) && (cnt_q == '0)) ||
                      (capture && (WAIT_CYCLES == 0));

  always_comb begin
    wr_word = mem[idx];
    for (int k = 0; k < NB; k++)
      if (acc_be[k]) wr_word[k*8 +: 8] = acc_wdata[k*8 +: 8];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready      = (state_q == DONE) || ((state_q == IDLE) && !req);
    mem_result = result_q;
    addr_err   = err_q;
  end

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    if (capture) begin
      addr_d  = address;
      wdata_d = wdata;
      be_d    = byte_en;
      wr_d    = mem_write;
      cnt_d   = CNT_LOAD;
    end else if ((state_q == BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (enter_done) begin
      result_d = (!acc_wr && in_range) ? mem[idx] : '0;
      err_d    = !in_range;
    end else if (state_q == DONE) begin
      result_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Array is never cleared; a write aborted by reset never reaches this commit.
  always_ff @(posedge clk) begin
    if (!rst && enter_done && acc_wr && in_range) mem[idx] <= wr_word;
  end
endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: default build (3 wait states) and a
// zero-wait-state build driven side by side.
module tb_data_memory_ws;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd0 = 0, wr0 = 0, rdy0, err0;
  logic [31:0] addr0 = 0, wd0 = 0, res0;
  logic [3:0]  be0 = 0;
  logic        rd1 = 0, wr1 = 0, rdy1, err1;
  logic [31:0] addr1 = 0, wd1 = 0, res1;
  logic [3:0]  be1 = 0;

  int total = 0;
  int bad   = 0;

  logic [31:0] r;
  logic        e;
  int          lows;

  data_memory_ws u0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .address(addr0),
    .wdata(wd0), .byte_en(be0), .ready(rdy0), .mem_result(res0), .addr_err(err0));

  data_memory_ws #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .address(addr1),
    .wdata(wd1), .byte_en(be1), .ready(rdy1), .mem_result(res1), .addr_err(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: drive at negedge, count ready-low cycles, sample in DONE,
  // then confirm the outputs clear on the DONE exit edge.
  task automatic acc(input bit d, input logic rdv, input logic wrv,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] res, output logic err, output int nlow);
    int n;
    @(negedge clk);
    if (d) begin rd1 = rdv; wr1 = wrv; addr1 = a; wd1 = wd; be1 = be; end
    else   begin rd0 = rdv; wr0 = wrv; addr0 = a; wd0 = wd; be0 = be; end
    #1;
    nlow = 0;
    n    = 0;
    while (!(d ? rdy1 : rdy0) && n < 40) begin
      nlow++; n++;
      @(posedge clk); #1;
    end
    chk("no_hang", 32'(n < 40), 32'd1);
    res = d ? res1 : res0;
    err = d ? err1 : err0;
    if (d) begin rd1 = 0; wr1 = 0; end else begin rd0 = 0; wr0 = 0; end
    @(posedge clk); #1;
    chk("res_clear", d ? res1 : res0, 32'd0);
    chk("err_clear", 32'(d ? err1 : err0), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready0", 32'(rdy0), 32'd1);
    chk("rst_res0",   res0, 32'd0);
    chk("rst_err0",   32'(err0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    @(negedge clk); rst = 0;

    // 1: read idx 5
    acc(0, 1, 0, 32'd1044, 0, 4'h0, r, e, lows);
    chk("t1_lat", 32'(lows), 32'd4);
    chk("t1_res", r, 32'd5);
    chk("t1_err", 32'(e), 32'd0);

    // 2: full write then reads, including low address bits set
    acc(0, 0, 1, 32'd1032, 32'hDEADBEEF, 4'hF, r, e, lows);
    chk("t2_wr_res", r, 32'd0);
    chk("t2_wr_lat", 32'(lows), 32'd4);
    acc(0, 1, 0, 32'd1032, 0, 4'h0, r, e, lows);
    chk("t2_rd", r, 32'hDEADBEEF);
    acc(0, 1, 0, 32'd1035, 0, 4'h0, r, e, lows);
    chk("t2_rd_unaligned", r, 32'hDEADBEEF);

    // 3: single-lane write merges with old contents
    acc(0, 0, 1, 32'd1036, 32'h0000AB00, 4'b0010, r, e, lows);
    acc(0, 1, 0, 32'd1036, 0, 4'hF, r, e, lows);
    chk("t3_lane", r, 32'h0000AB03);

    // 4: out-of-range below and above, then boundaries
    acc(0, 1, 0, 32'd1020, 0, 4'h0, r, e, lows);
    chk("t4_lo_res", r, 32'd0);
    chk("t4_lo_err", 32'(e), 32'd1);
    chk("t4_lo_lat", 32'(lows), 32'd4);
    acc(0, 0, 1, 32'd1280, 32'h12345678, 4'hF, r, e, lows);
    chk("t4_hi_err", 32'(e), 32'd1);
    acc(0, 1, 0, 32'd1024, 0, 4'h0, r, e, lows);
    chk("t4_idx0", r, 32'd0);
    chk("t4_idx0_err", 32'(e), 32'd0);
    acc(0, 1, 0, 32'd1276, 0, 4'h0, r, e, lows);
    chk("t4_idx63", r, 32'd63);
    chk("t4_idx63_err", 32'(e), 32'd0);

    // 5: reset during the second BUSY cycle aborts the write
    @(negedge clk);
    wr0 = 1; addr0 = 32'd1048; wd0 = 32'hFFFFFFFF; be0 = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_busy", 32'(rdy0), 32'd0);
    rst = 1; #1;
    wr0 = 0; #1;
    chk("t5_rst_ready", 32'(rdy0), 32'd1);
    chk("t5_rst_res",   res0, 32'd0);
    chk("t5_rst_err",   32'(err0), 32'd0);
    @(negedge clk); rst = 0;
    acc(0, 1, 0, 32'd1048, 0, 4'h0, r, e, lows);
    chk("t5_not_committed", r, 32'd6);

    // 6: zero wait states, read+write treated as write
    acc(1, 1, 1, 32'd1028, 32'd7, 4'hF, r, e, lows);
    chk("t6_lat", 32'(lows), 32'd1);
    chk("t6_rw_res", r, 32'd0);
    acc(1, 1, 0, 32'd1028, 0, 4'h0, r, e, lows);
    chk("t6_rd", r, 32'd7);
    chk("t6_rd_lat", 32'(lows), 32'd1);

    // back-to-back reads: ready toggles 0,1,0,1
    @(negedge clk);
    rd1 = 1; addr1 = 32'd1028;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_b2b_ready", 32'(rdy1), 32'(i % 2));
      if (i % 2 == 1) chk("t6_b2b_res", res1, 32'd7);
      @(negedge clk);
    end
    rd1 = 0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
